// File: rtl/uart_mult_sequencer.sv
// Operand collector and product streamer between uart_rx/uart_tx and the multiplier pins.
// Define UART_MULT_CHKSUM_EN to append a third XOR checksum byte to every reply.
module uart_mult_sequencer #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       err_timeout,
    output logic       rx_overrun,
    output logic [2:0] dbg_state_o
);

    // Handshake: rx_valid is a single-cycle strobe with no back-pressure; tx_start is
    // asserted only while tx_ready=1 and the byte is taken on that same rising edge.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_B = 3'd1,
        MUL   = 3'd2,
        SEND  = 3'd3,
        ACK   = 3'd4,
        DONE  = 3'd5
    } state_t;

`ifdef UART_MULT_CHKSUM_EN
    localparam logic [1:0] LAST = 2'd2;
`else
    localparam logic [1:0] LAST = 2'd1;
`endif

    state_t      state_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] p_q;
    logic [1:0]  idx_q;
    logic [23:0] timer_q;
    logic [7:0]  tx_data_q;
    logic        err_q;
    logic        ovr_q;

    logic [15:0] prod_d;
    logic [7:0]  next_byte_d;

    assign prod_d = {8'h00, a_q} * {8'h00, b_q};

    // Byte that follows the one currently on tx_data.
    always_comb begin
        next_byte_d = p_q[7:0];
`ifdef UART_MULT_CHKSUM_EN
        if (idx_q == 2'd1) begin
            next_byte_d = a_q ^ b_q ^ p_q[15:8] ^ p_q[7:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            p_q       <= 16'h0000;
            idx_q     <= 2'd0;
            timer_q   <= 24'd0;
            tx_data_q <= 8'h00;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            ovr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        a_q     <= rx_data;
                        timer_q <= 24'd0;
                        state_q <= GET_B;
                    end
                end
                GET_B: begin
                    // A byte landing in the expiry cycle still wins over the timeout.
                    if (rx_valid) begin
                        b_q     <= rx_data;
                        state_q <= MUL;
                    end else if (timer_q == TIMEOUT_CYC - 24'd1) begin
                        err_q   <= 1'b1;
                        a_q     <= 8'h00;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 24'd1;
                    end
                end
                MUL: begin
                    p_q       <= prod_d;
                    idx_q     <= 2'd0;
                    tx_data_q <= prod_d[15:8];
                    state_q   <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!tx_ready) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (tx_ready) begin
                        if (idx_q == LAST) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q     <= idx_q + 2'd1;
                            tx_data_q <= next_byte_d;
                            state_q   <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (rx_valid && (state_q inside {MUL, SEND, ACK, DONE})) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign tx_start    = (state_q == SEND) && tx_ready;
    assign tx_data     = tx_data_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;
    assign rx_overrun  = ovr_q;
    assign dbg_state_o = state_q;

endmodule
